// File: rtl/apb_pkg.sv
// ============================================================================
//  Module   : apb_pkg
//  Purpose  : Shared types and defaults for the two-requester APB master
//             (phase state encoding, default bus widths, request bundle).
//  Ports    : none (package)
//  Options  : none
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int APB_ADDR_WIDTH = 16;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Request bundle at the default widths.
    typedef struct packed {
        logic                        write;
        logic [APB_ADDR_WIDTH-1:0]   addr;
        logic [APB_DATA_WIDTH-1:0]   wdata;
        logic [APB_DATA_WIDTH/8-1:0] strb;
    } apb_req_t;

endpackage

`default_nettype wire

// File: rtl/apb_master_arbiter_if.sv
// ============================================================================
//  Module   : apb_master_arbiter_if
//  Purpose  : Bundles both requester handshakes and the APB master bus.
//  Ports    : none; signals reqN_* (N=0,1), PSEL/PENABLE/PWRITE/PADDR/
//             PWDATA/PSTRB, PRDATA/PREADY/PSLVERR.
//             modport master : the arbiter's view
//             modport slave  : the requesters' and slave mux's view
//  Options  : none
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_master_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  req0_valid;
    logic                  req0_write;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic [STRB_WIDTH-1:0] req0_strb;
    logic                  req0_accept;
    logic                  req0_done;
    logic [DATA_WIDTH-1:0] req0_rdata;
    logic                  req0_err;

    logic                  req1_valid;
    logic                  req1_write;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic [STRB_WIDTH-1:0] req1_strb;
    logic                  req1_accept;
    logic                  req1_done;
    logic [DATA_WIDTH-1:0] req1_rdata;
    logic                  req1_err;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata, req0_strb,
        output req0_accept, req0_done, req0_rdata, req0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata, req1_strb,
        output req1_accept, req1_done, req1_rdata, req1_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata, req0_strb,
        input  req0_accept, req0_done, req0_rdata, req0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata, req1_strb,
        input  req1_accept, req1_done, req1_rdata, req1_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
// ============================================================================
//  Module   : apb_rr_arbiter
//  Purpose  : Two-input round-robin grant. Grant is combinational; only the
//             last-grant pointer is registered.
//  Ports    : clk, rst_n (sync, active-low)
//             valid[1:0]  : pending requests
//             update      : a grant taken this cycle should move the pointer
//             grant_valid : at least one request pending
//             grant_idx   : winning requester
//  Options  : none
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       update,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic last_grant;

    assign grant_valid = |valid;

    // On a tie the requester that did not win last time goes next;
    // otherwise the lone requester wins.
    always_comb begin
        grant_idx = valid[1];
        if (valid == 2'b11) begin
            grant_idx = ~last_grant;
        end
    end

    // Pointer starts at 1 so requester 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (update && grant_valid) begin
            last_grant <= grant_idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// ============================================================================
//  Module   : apb_master_arbiter
//  Purpose  : Two-requester APB master. Round-robin arbitration followed by
//             APB SETUP/ACCESS sequencing with wait states; read data and
//             error status are returned to the granted requester.
//  Ports    : PCLK     - clock
//             PRESETn  - synchronous active-low reset
//             bus      - apb_master_arbiter_if.master (requesters + APB)
//  Options  : APB_TIMEOUT_EN - abort a transfer with err=1 after
//             TIMEOUT_CYCLES ACCESS cycles without PREADY.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_master_arbiter_if.master bus
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
    } req_t;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state;
    logic                  owner;
    logic                  arb_valid;
    logic                  arb_idx;
    req_t                  req_sel;
    logic                  xfer_end;
    logic                  xfer_err;
    logic [DATA_WIDTH-1:0] xfer_rdata;

`ifdef APB_TIMEOUT_EN
    localparam int TO_WIDTH = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                              $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    logic [TO_WIDTH-1:0] to_cnt;
`endif

    // The pointer only moves when a grant is actually taken, i.e. in IDLE.
    apb_rr_arbiter u_arb (
        .clk         (PCLK),
        .rst_n       (PRESETn),
        .valid       ({bus.req1_valid, bus.req0_valid}),
        .update      (state == IDLE),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    always_comb begin
        if (arb_idx) begin
            req_sel = '{bus.req1_write, bus.req1_addr, bus.req1_wdata, bus.req1_strb};
        end else begin
            req_sel = '{bus.req0_write, bus.req0_addr, bus.req0_wdata, bus.req0_strb};
        end
    end

    // Completion of the current ACCESS cycle and the result to hand back.
    always_comb begin
        xfer_end   = bus.PREADY;
        xfer_err   = bus.PSLVERR;
        xfer_rdata = bus.PWRITE ? '0 : bus.PRDATA;
`ifdef APB_TIMEOUT_EN
        // PREADY in the last allowed cycle still wins over the abort.
        if (!bus.PREADY && (to_cnt == TO_LAST)) begin
            xfer_end   = 1'b1;
            xfer_err   = 1'b1;
            xfer_rdata = '0;
        end
`endif
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state           <= IDLE;
            owner           <= 1'b0;
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.PWRITE      <= 1'b0;
            bus.PADDR       <= '0;
            bus.PWDATA      <= '0;
            bus.PSTRB       <= '0;
            bus.req0_accept <= 1'b0;
            bus.req0_done   <= 1'b0;
            bus.req0_rdata  <= '0;
            bus.req0_err    <= 1'b0;
            bus.req1_accept <= 1'b0;
            bus.req1_done   <= 1'b0;
            bus.req1_rdata  <= '0;
            bus.req1_err    <= 1'b0;
`ifdef APB_TIMEOUT_EN
            to_cnt          <= '0;
`endif
        end else begin
            bus.req0_accept <= 1'b0;
            bus.req1_accept <= 1'b0;
            bus.req0_done   <= 1'b0;
            bus.req1_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state       <= SETUP;
                        owner       <= arb_idx;
                        bus.PSEL    <= 1'b1;
                        bus.PENABLE <= 1'b0;
                        bus.PWRITE  <= req_sel.write;
                        bus.PADDR   <= req_sel.addr;
                        bus.PWDATA  <= req_sel.wdata;
                        bus.PSTRB   <= req_sel.write ? req_sel.strb : '0;
                        if (arb_idx) begin
                            bus.req1_accept <= 1'b1;
                        end else begin
                            bus.req0_accept <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    to_cnt      <= '0;
`endif
                end
                ACCESS: begin
                    if (xfer_end) begin
                        state       <= IDLE;
                        bus.PSEL    <= 1'b0;
                        bus.PENABLE <= 1'b0;
                        if (owner) begin
                            bus.req1_done  <= 1'b1;
                            bus.req1_rdata <= xfer_rdata;
                            bus.req1_err   <= xfer_err;
                        end else begin
                            bus.req0_done  <= 1'b1;
                            bus.req0_rdata <= xfer_rdata;
                            bus.req0_err   <= xfer_err;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
// ============================================================================
//  Module   : tb_apb_master_arbiter
//  Purpose  : Self-checking bench for apb_master_arbiter. A transaction-level
//             model predicts every registered output each cycle; directed
//             scenarios add literal expectations on latency and results.
//  Options  : APB_TIMEOUT_EN enables the timeout scenario (TIMEOUT_CYCLES=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_arbiter;
    import apb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rstn),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- slave mux model ----------------
    int          wait_n    = 0;
    bit          stuck     = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    bit          slv_err   = 1'b0;
    int          acnt      = 0;

    always @(negedge clk) begin
        if (bus.PSEL && bus.PENABLE) acnt++;
        else acnt = 0;
        bus.PREADY  = bus.PSEL && bus.PENABLE && !stuck && (acnt > wait_n);
        bus.PRDATA  = slv_rdata;
        bus.PSLVERR = slv_err;
    end

    // ---------------- transaction-level model ----------------
    apb_req_t    m_req;
    bit          m_busy;
    int          m_owner;
    int          m_acc;
    bit          m_last;
    logic        e_psel, e_pen, e_pwrite;
    logic [15:0] e_paddr;
    logic [31:0] e_pwdata;
    logic [3:0]  e_pstrb;
    logic [1:0]  e_acc, e_done;
    logic [31:0] e_rdata [2];
    logic        e_err   [2];

    function automatic apb_req_t req_of(input int i);
        apb_req_t r;
        if (i == 1) r = '{bus.req1_write, bus.req1_addr, bus.req1_wdata, bus.req1_strb};
        else        r = '{bus.req0_write, bus.req0_addr, bus.req0_wdata, bus.req0_strb};
        return r;
    endfunction

    task automatic complete(input logic err, input logic [31:0] rd);
        m_busy = 1'b0;
        e_psel = 1'b0;
        e_pen  = 1'b0;
        e_done[m_owner]  = 1'b1;
        e_rdata[m_owner] = rd;
        e_err[m_owner]   = err;
    endtask

    always @(posedge clk) begin
        if (!rstn) begin
            m_busy = 1'b0; m_last = 1'b1; m_owner = 0; m_acc = 0;
            e_psel = 1'b0; e_pen = 1'b0; e_pwrite = 1'b0;
            e_paddr = '0; e_pwdata = '0; e_pstrb = '0;
            e_acc = '0; e_done = '0;
            e_rdata[0] = '0; e_rdata[1] = '0; e_err[0] = 1'b0; e_err[1] = 1'b0;
        end else begin
            e_acc  = '0;
            e_done = '0;
            if (!m_busy) begin
                if (bus.req0_valid || bus.req1_valid) begin
                    int w;
                    if (bus.req0_valid && bus.req1_valid) w = m_last ? 0 : 1;
                    else w = bus.req1_valid ? 1 : 0;
                    m_busy = 1'b1; m_owner = w; m_last = (w == 1); m_acc = 0;
                    m_req = req_of(w);
                    e_acc[w] = 1'b1;
                    e_psel = 1'b1; e_pen = 1'b0;
                    e_pwrite = m_req.write;
                    e_paddr  = m_req.addr;
                    e_pwdata = m_req.wdata;
                    e_pstrb  = m_req.write ? m_req.strb : 4'h0;
                end
            end else if (!e_pen) begin
                e_pen = 1'b1;
            end else begin
                m_acc++;
                if (bus.PREADY) complete(bus.PSLVERR, m_req.write ? 32'h0 : bus.PRDATA);
`ifdef APB_TIMEOUT_EN
                else if (m_acc == TO) complete(1'b1, 32'h0);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("psel",    bus.PSEL,        e_psel);
            chk("penable", bus.PENABLE,     e_pen);
            chk("pwrite",  bus.PWRITE,      e_pwrite);
            chk("paddr",   bus.PADDR,       e_paddr);
            chk("pwdata",  bus.PWDATA,      e_pwdata);
            chk("pstrb",   bus.PSTRB,       e_pstrb);
            chk("accept0", bus.req0_accept, e_acc[0]);
            chk("accept1", bus.req1_accept, e_acc[1]);
            chk("done0",   bus.req0_done,   e_done[0]);
            chk("done1",   bus.req1_done,   e_done[1]);
            chk("rdata0",  bus.req0_rdata,  e_rdata[0]);
            chk("rdata1",  bus.req1_rdata,  e_rdata[1]);
            chk("err0",    bus.req0_err,    e_err[0]);
            chk("err1",    bus.req1_err,    e_err[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int idx, input logic v, input logic wr,
                           input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        if (idx == 1) begin
            bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = a;
            bus.req1_wdata = d; bus.req1_strb = s;
        end else begin
            bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = a;
            bus.req0_wdata = d; bus.req0_strb = s;
        end
    endtask

    // Latency counts negedges from raising valid up to the one showing done.
    task automatic run_req(input int idx, input logic wr, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [15:0] a_seen,
                           output logic [3:0] s_seen, output logic [31:0] rd,
                           output logic er);
        bit got_acc  = 1'b0;
        bit got_done = 1'b0;
        lat = 0; a_seen = '0; s_seen = '0; rd = '0; er = 1'b0;
        @(negedge clk);
        set_req(idx, 1'b1, wr, a, d, s);
        for (int k = 0; k < 200 && !got_done; k++) begin
            @(negedge clk);
            lat++;
            if (!got_acc && (idx == 1 ? bus.req1_accept : bus.req0_accept)) begin
                got_acc = 1'b1;
                a_seen  = bus.PADDR;
                s_seen  = bus.PSTRB;
                if (idx == 1) bus.req1_valid = 1'b0;
                else          bus.req0_valid = 1'b0;
            end
            if (idx == 1 ? bus.req1_done : bus.req0_done) begin
                got_done = 1'b1;
                rd = (idx == 1) ? bus.req1_rdata : bus.req0_rdata;
                er = (idx == 1) ? bus.req1_err   : bus.req0_err;
            end
        end
        chk("xfer_completed", got_done, 1'b1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int          lat;
        logic [15:0] a_seen;
        logic [3:0]  s_seen;
        logic [31:0] rd;
        logic        er;
        logic [3:0]  order;
        int          ndone;
        bit          ok;

        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);

        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_psel",    bus.PSEL,        1'b0);
        chk("rst_accept0", bus.req0_accept, 1'b0);
        chk("rst_rdata1",  bus.req1_rdata,  32'h0);
        rstn = 1'b1;

        // Single zero-wait read; strobes must be suppressed on reads.
        slv_rdata = 32'hDEADBEEF; wait_n = 0;
        run_req(0, 1'b0, 16'h1004, 32'h0, 4'hF, lat, a_seen, s_seen, rd, er);
        chk("rd_latency", lat,    3);
        chk("rd_paddr",   a_seen, 16'h1004);
        chk("rd_pstrb",   s_seen, 4'h0);
        chk("rd_rdata",   rd,     32'hDEADBEEF);
        chk("rd_err",     er,     1'b0);

        // Write with two wait states from requester 1.
        wait_n = 2;
        run_req(1, 1'b1, 16'h2008, 32'h000000A5, 4'h1, lat, a_seen, s_seen, rd, er);
        chk("wr_latency", lat,    5);
        chk("wr_pstrb",   s_seen, 4'h1);
        chk("wr_rdata",   rd,     32'h0);
        chk("wr_err",     er,     1'b0);

        // Contention: both held, four completions must alternate 0,1,0,1.
        wait_n = 0; slv_rdata = 32'h12345678;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 16'h0100, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b1, 16'h0200, 32'hCAFE0001, 4'h3);
        order = '0; ndone = 0;
        for (int k = 0; k < 100 && ndone < 4; k++) begin
            @(negedge clk);
            if (bus.req0_done) begin order[ndone] = 1'b0; ndone++; end
            if (bus.req1_done) begin order[ndone] = 1'b1; ndone++; end
            if (ndone >= 4) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end
        chk("rr_count", ndone, 4);
        chk("rr_order", order, 4'b1010);

        // Slave error on a read.
        slv_err = 1'b1; slv_rdata = 32'h0BADF00D;
        run_req(0, 1'b0, 16'h3000, 32'h0, 4'h0, lat, a_seen, s_seen, rd, er);
        chk("slverr_err",   er, 1'b1);
        chk("slverr_rdata", rd, 32'h0BADF00D);
        slv_err = 1'b0;

        // Reset in the middle of a stalled ACCESS phase.
        stuck = 1'b1;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 16'h5000, 32'h0, 4'h0);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (bus.req0_accept) bus.req0_valid = 1'b0;
            if (bus.PSEL && bus.PENABLE) ok = 1'b1;
        end
        chk("rstmid_reached_access", ok, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        chk("rstmid_psel",    bus.PSEL,      1'b0);
        chk("rstmid_penable", bus.PENABLE,   1'b0);
        chk("rstmid_done0",   bus.req0_done, 1'b0);
        rstn = 1'b1; stuck = 1'b0; slv_rdata = 32'h600DCAFE;
        run_req(1, 1'b0, 16'h6000, 32'h0, 4'h0, lat, a_seen, s_seen, rd, er);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_rdata",   rd,  32'h600DCAFE);

`ifdef APB_TIMEOUT_EN
        // PREADY never arrives: abort after exactly TO ACCESS cycles.
        stuck = 1'b1; slv_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 16'h7000, 32'h0, 4'h0);
        ndone = 0; ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (bus.req0_accept) bus.req0_valid = 1'b0;
            if (bus.PSEL && bus.PENABLE) ndone++;
            if (bus.req0_done) begin
                ok = 1'b1; rd = bus.req0_rdata; er = bus.req0_err;
            end
        end
        chk("to_done",          ok,    1'b1);
        chk("to_access_cycles", ndone, TO);
        chk("to_err",           er,    1'b1);
        chk("to_rdata",         rd,    32'h0);
        stuck = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-requester APB master. Shares the peripheral APB bus between the AHB-to-APB bridge path (requester 0) and a second bus master such as a DMA or debug engine (requester 1).
- Arbitrates round-robin and sequences the APB SETUP and ACCESS phases, including wait states.
- Returns read data and error status to the winning requester.
- Sits between the masters and the peripheral decoder/slave mux in the APB subsystem.

Parameters:
- ADDR_WIDTH, 16, width of PADDR and reqN_addr.
- DATA_WIDTH, 32, width of the data buses; PSTRB width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles when APB_TIMEOUT_EN is defined. Must be at least 1.

Ports:
- PCLK  in  1  APB clock; the only clock.
- PRESETn  in  1  reset; synchronous, active-low.
- reqN_valid  in  1  requester N (N=0,1) has a transfer pending.
- reqN_write  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_WIDTH  transfer address.
- reqN_wdata  in  DATA_WIDTH  write data.
- reqN_strb  in  DATA_WIDTH/8  write byte strobes.
- reqN_accept  out  1  one-cycle pulse: request captured.
- reqN_done  out  1  one-cycle pulse: transfer complete.
- reqN_rdata  out  DATA_WIDTH  read data, valid while reqN_done is high.
- reqN_err  out  1  PSLVERR (or timeout) result, valid while reqN_done is high.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  DATA_WIDTH/8  APB byte strobes.
- PRDATA  in  DATA_WIDTH  read data from the slave mux.
- PREADY, PSLVERR  in  1 each  slave-mux handshake.

Behaviour:
- Reset: the state machine goes to IDLE and the last-grant pointer is set to 1, so requester 0 wins the first tie.
  - All outputs reset to 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, both accept, done, rdata and err outputs.
- All outputs are registered.
- IDLE:
  - No valid request: stay in IDLE.
  - Exactly one valid request: grant it.
  - Both valid: grant the requester other than the last grantee.
  - On grant, the next edge captures write, addr, wdata and strb, pulses reqN_accept for 1 cycle, updates the last-grant pointer and moves to SETUP.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven from the captured fields. Always moves to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, address and data held stable.
  - PREADY=0: stay in ACCESS (wait state).
  - PREADY=1: go to IDLE. The next edge drives PSEL=PENABLE=0 and pulses reqN_done for the grantee.
    - reqN_rdata = PRDATA on reads, 0 on writes.
    - reqN_err = PSLVERR.
- Latency with zero wait states:
  - Cycle 0: IDLE with valid high; accept is registered at the end of cycle 0.
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS with PREADY=1.
  - Cycle 3: done. Each wait state adds 1 cycle.
- Back-to-back: in the IDLE cycle that carries done, a new grant may be taken, giving one IDLE cycle between transfers.
- Requester rules:
  - Hold valid and fields stable until accept.
  - Valid must not be reasserted for a new transfer before done.
  - Changes to request inputs after accept do not affect the transfer in flight.
- PSTRB is forced to 0 on reads.
- A grant never changes while in SETUP or ACCESS. The non-granted requester's accept and done stay low.
- Reset asserted mid-transfer: next edge returns to IDLE with PSEL=PENABLE=0. No done pulse; the transfer is lost.
- Non-granted rdata and err hold their previous values.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: an 8-bit-minimum counter, sized by $clog2(TIMEOUT_CYCLES+1), counts ACCESS cycles.
  - If PREADY is still 0 after TIMEOUT_CYCLES ACCESS cycles, the transfer is aborted: go to IDLE, pulse done with err=1 and rdata=0.
  - PREADY=1 in the final allowed cycle counts as a normal completion.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS}.
  - Default ADDR_WIDTH and DATA_WIDTH localparams.
  - Request struct type bundling write/addr/wdata/strb.
- One natural sub-module: apb_rr_arbiter, a 2-input round-robin grant with a last-grant pointer, purely combinational grant plus pointer register. The APB phase FSM stays in the top module.

Test Plan:
- Single read: req0 read 0x1004, PREADY=1 immediately, PRDATA=0xDEADBEEF -> accept0 at cycle 0; PSEL at cycle 1; PENABLE at cycle 2; done0=1, rdata0=0xDEADBEEF, err0=0 at cycle 3.
- Write with 2 wait states: req1 write 0x2008, wdata=0x000000A5, strb=0x1 -> PWDATA/PSTRB stable for 3 ACCESS cycles; done1 appears 2 cycles later than the zero-wait case; PSTRB=0x1.
- Contention: req0 and req1 held continuously, 4 transfers -> grants alternate 0,1,0,1 from reset; no overlapping PSEL.
- Slave error: req0 read with PSLVERR=1 when PREADY=1 -> done0=1, err0=1.
- Reset mid-ACCESS: PRESETn=0 while PREADY=0 -> next edge PSEL=PENABLE=0, no done pulse; after release, req1 alone is granted normally.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and PREADY stuck at 0 -> exactly 4 ACCESS cycles, then done=1, err=1, rdata=0.
